neural_soc_sysid_checker: RTL and testbench

Avalon-MM master that reads the system ID peripheral's control slave (word 0 = ID, word 1 = timestamp) and compares both words against expected values fixed at build time. It sits beside the sysid slave in the neural SoC. It gates neural-accelerator enable until the hardware image is confirmed to match the software build. It handles waitrequest stalls, a per-read timeout, and bounded retries.

---
 rtl/neural_soc_pkg.sv | 23 ++
 rtl/neural_soc_sysid_read_port.sv | 56 +++++
 rtl/neural_soc_sysid_checker.sv | 179 +++++++++++++++++
 tb/tb_neural_soc_sysid_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_soc_pkg.sv
// Shared definitions for the neural SoC system-ID checker.
package neural_soc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1480977927;

  // True in the states where a read is requested or outstanding.
  function automatic logic is_active_state(input sysid_state_e s);
    return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
  endfunction

endpackage

// File: rtl/neural_soc_sysid_read_port.sv
// Avalon-MM single-read port: issues one read, tracks its acceptance and
// reply, and flags a timeout when neither arrives in time.
module neural_soc_sysid_read_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic issue,
  input  logic issue_address,
  input  logic avm_waitrequest,
  input  logic avm_readdatavalid,
  output logic avm_read,
  output logic avm_address,
  output logic accepted,
  output logic data_valid,
  output logic timed_out
);

  logic       pending;
  logic [7:0] timeout_cnt;
  logic       active;

  assign accepted   = avm_read && !avm_waitrequest;
  assign active     = avm_read || pending;
  // Replies only count while a read is outstanding; stray ones are dropped.
  assign data_valid = pending && avm_readdatavalid;
  // Acceptance or data in the timeout cycle takes priority over the timeout.
  assign timed_out  = active && !accepted && !data_valid &&
                      (timeout_cnt == 8'(TIMEOUT_CYCLES));

  // Request/outstanding tracking plus the per-read timeout counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      pending     <= 1'b0;
      timeout_cnt <= 8'd0;
    end else if (issue) begin
      avm_read    <= 1'b1;
      avm_address <= issue_address;
      pending     <= 1'b0;
      timeout_cnt <= 8'd0;
    end else if (accepted) begin
      avm_read    <= 1'b0;
      pending     <= 1'b1;
      timeout_cnt <= 8'd0;
    end else if (data_valid || timed_out) begin
      avm_read    <= 1'b0;
      pending     <= 1'b0;
      timeout_cnt <= 8'd0;
    end else if (active) begin
      timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/neural_soc_sysid_checker.sv
// Reads the sysid slave's ID and timestamp words and reports whether the
// hardware image matches the expected build, with timeout and retries.
module neural_soc_sysid_checker
  import neural_soc_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_e state;
  sysid_state_e state_next;
  logic         auto_pending;
  logic [1:0]   retry_cnt;
  logic         can_retry;
  logic         issue;
  logic         issue_address;
  logic         retry_now;
  logic         give_up;
  logic         accepted;
  logic         data_valid;
  logic         timed_out;

  assign can_retry = retry_cnt < 2'(MAX_RETRIES);

  neural_soc_sysid_read_port #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read_port (
    .clock             (clock),
    .reset_n           (reset_n),
    .issue             (issue),
    .issue_address     (issue_address),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_read          (avm_read),
    .avm_address       (avm_address),
    .accepted          (accepted),
    .data_valid        (data_valid),
    .timed_out         (timed_out)
  );

  // State register; the auto-start request lives for one cycle after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_next;
      auto_pending <= 1'b0;
    end
  end

  // Next-state logic and read-issue / retry decisions.
  always_comb begin
    state_next    = state;
    issue         = 1'b0;
    issue_address = SYSID_ADDR_ID;
    retry_now     = 1'b0;
    give_up       = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pending) begin
          state_next = ID_REQ;
          issue      = 1'b1;
        end
      end
      ID_REQ, TS_REQ: begin
        issue_address = (state == TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        if (accepted) begin
          state_next = (state == TS_REQ) ? TS_WAIT : ID_WAIT;
        end else if (timed_out) begin
          if (can_retry) begin
            retry_now = 1'b1;
            issue     = 1'b1;
          end else begin
            give_up    = 1'b1;
            state_next = FINISH;
          end
        end
      end
      ID_WAIT: begin
        if (data_valid) begin
          state_next    = TS_REQ;
          issue         = 1'b1;
          issue_address = SYSID_ADDR_TS;
        end else if (timed_out) begin
          if (can_retry) begin
            retry_now  = 1'b1;
            issue      = 1'b1;
            state_next = ID_REQ;
          end else begin
            give_up    = 1'b1;
            state_next = FINISH;
          end
        end
      end
      TS_WAIT: begin
        issue_address = SYSID_ADDR_TS;
        if (data_valid) begin
          state_next = FINISH;
        end else if (timed_out) begin
          if (can_retry) begin
            retry_now  = 1'b1;
            issue      = 1'b1;
            state_next = TS_REQ;
          end else begin
            give_up    = 1'b1;
            state_next = FINISH;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags, retry count and result evaluation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FINISH);
      if (state == IDLE && state_next == ID_REQ) begin
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        retry_cnt   <= 2'd0;
      end else if (retry_now && is_active_state(state)) begin
        retry_cnt <= retry_cnt + 2'd1;
      end else if (state == ID_WAIT && data_valid) begin
        retry_cnt <= 2'd0;
      end
      if (give_up) begin
        timeout_err <= 1'b1;
      end
      if (state == FINISH) begin
        pass <= !timeout_err && (id_value == EXPECTED_ID) &&
                (ts_value == EXPECTED_TIMESTAMP);
      end
    end
  end

  // Capture returned words; they hold until the next successful read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      if (state == ID_WAIT && data_valid) begin
        id_value <= avm_readdata;
      end
      if (state == TS_WAIT && data_valid) begin
        ts_value <= avm_readdata;
      end
    end
  end

endmodule

// File: tb/tb_neural_soc_sysid_checker.sv
// Directed bench for the sysid checker with a behavioural sysid slave and
// a scoreboard of expected check results.
module tb_neural_soc_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'h0000_0000;
  localparam logic [31:0] GOOD_TS = 32'd1480977927;
  localparam logic [31:0] BAD_TS  = 32'd1480977928;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave model configuration and state.
  int          ws_cycles = 0;
  int          stall_left = 0;
  int          drop_id = 0;
  int          drop_ts = 0;
  bit          late_inject = 1'b0;
  logic [31:0] id_data = GOOD_ID;
  logic [31:0] ts_data = GOOD_TS;
  bit          resp_pending = 1'b0;
  logic        resp_addr = 1'b0;
  int          read_count [2];
  int          stab_viol = 0;
  bit          mon_prev_stall = 1'b0;
  bit          mon_prev_accept = 1'b0;
  logic        mon_prev_addr = 1'b0;

  typedef struct {
    logic        pass_v;
    logic        terr_v;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];

  neural_soc_sysid_checker #(
    .EXPECTED_ID        (GOOD_ID),
    .EXPECTED_TIMESTAMP (GOOD_TS),
    .TIMEOUT_CYCLES     (12),
    .MAX_RETRIES        (3),
    .AUTO_START         (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Sysid slave and handshake monitor, evaluated mid-cycle.
  always @(negedge clock) begin
    if (!reset_n) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      resp_pending      = 1'b0;
      stall_left        = ws_cycles;
      mon_prev_stall    = 1'b0;
      mon_prev_accept   = 1'b0;
    end else begin
      if (mon_prev_stall && (!avm_read || avm_address != mon_prev_addr)) stab_viol++;
      if (mon_prev_accept && avm_read) stab_viol++;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      if (resp_pending) begin
        resp_pending = 1'b0;
        if (resp_addr == 1'b0) begin
          if (drop_id > 0) drop_id--;
          else begin avm_readdatavalid = 1'b1; avm_readdata = id_data; end
        end else begin
          if (drop_ts > 0) drop_ts--;
          else begin avm_readdatavalid = 1'b1; avm_readdata = ts_data; end
        end
      end
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          if (late_inject && avm_address == 1'b1 && !avm_readdatavalid) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEAD_BEEF;
            late_inject       = 1'b0;
          end
        end else begin
          resp_pending = 1'b1;
          resp_addr    = avm_address;
          stall_left   = ws_cycles;
          read_count[avm_address]++;
        end
      end
      mon_prev_stall  = avm_read && avm_waitrequest;
      mon_prev_accept = avm_read && !avm_waitrequest;
      mon_prev_addr   = avm_address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pushExpect(input logic p, input logic t, input logic [31:0] id,
                            input logic [31:0] ts, input int lat, input int sc);
    exp_t e;
    e.pass_v = p; e.terr_v = t; e.id_v = id; e.ts_v = ts; e.lat = lat; e.start_cyc = sc;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic p, input logic t, input logic [31:0] id,
                               input logic [31:0] ts, input int lat);
    @(posedge clock); #1;
    start = 1'b1;
    pushExpect(p, t, id, ts, lat, cyc);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    bit   seen;
    int   dcyc;
    seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    dcyc = cyc;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (e.lat >= 0) chk({tag, "_latency"}, 32'(dcyc - e.start_cyc), 32'(e.lat));
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass_v));
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(e.terr_v));
      chk({tag, "_id_value"}, id_value, e.id_v);
      chk({tag, "_ts_value"}, ts_value, e.ts_v);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clock);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int base0;
    int base1;
    int r;
    bit hit;
    read_count[0] = 0;
    read_count[1] = 0;

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_address", 32'(avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);

    // Auto-start after reset release, matching slave.
    reset_n = 1'b1;
    pushExpect(1'b1, 1'b0, GOOD_ID, GOOD_TS, 6, cyc);
    checkOutput("auto_match");

    // Explicit start, matching slave, zero wait.
    applyStimulus(1'b1, 1'b0, GOOD_ID, GOOD_TS, 6);
    chk("match_busy_after_start", 32'(busy), 32'd1);
    checkOutput("match");

    // Timestamp mismatch.
    ts_data = BAD_TS;
    applyStimulus(1'b0, 1'b0, GOOD_ID, BAD_TS, 6);
    checkOutput("mismatch");
    ts_data = GOOD_TS;

    // Ten-cycle waitrequest stall on each read, with an ignored start pulse.
    @(posedge clock); #1;
    ws_cycles = 10;
    stall_left = 10;
    applyStimulus(1'b1, 1'b0, GOOD_ID, GOOD_TS, 26);
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    checkOutput("stall");
    repeat (3) @(negedge clock);
    chk("stall_start_ignored", 32'(busy), 32'd0);
    @(posedge clock); #1;
    ws_cycles = 0;
    stall_left = 0;

    // Timestamp reply withheld on every attempt: four reads then give up.
    base0 = read_count[0];
    base1 = read_count[1];
    drop_ts = 4;
    applyStimulus(1'b0, 1'b1, GOOD_ID, GOOD_TS, -1);
    checkOutput("timeout");
    chk("timeout_ts_reads", 32'(read_count[1] - base1), 32'd4);
    chk("timeout_id_reads", 32'(read_count[0] - base0), 32'd1);
    drop_ts = 0;

    // ID read times out once then succeeds; stray reply during TS stall.
    @(posedge clock); #1;
    ws_cycles = 3;
    stall_left = 3;
    drop_id = 1;
    late_inject = 1'b1;
    base0 = read_count[0];
    applyStimulus(1'b1, 1'b0, GOOD_ID, GOOD_TS, -1);
    checkOutput("recovery");
    chk("recovery_id_reads", 32'(read_count[0] - base0), 32'd2);
    chk("recovery_late_used", 32'(late_inject), 32'd0);
    @(posedge clock); #1;
    ws_cycles = 0;
    stall_left = 0;

    // Reset while waiting for the timestamp reply, then auto restart.
    base1 = read_count[1];
    drop_ts = 1;
    applyStimulus(1'b1, 1'b0, GOOD_ID, GOOD_TS, -1);
    void'(sb.pop_back());
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (read_count[1] > base1) begin hit = 1'b1; break; end
    end
    chk("reset_reached_ts_wait", 32'(hit), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_avm_read", 32'(avm_read), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_id_value", id_value, 32'd0);
    chk("midrst_ts_value", ts_value, 32'd0);
    drop_ts = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    r = cyc;
    pushExpect(1'b1, 1'b0, GOOD_ID, GOOD_TS, 6, r);
    @(posedge clock);
    @(negedge clock);
    chk("restart_avm_read", 32'(avm_read), 32'd1);
    chk("restart_avm_address", 32'(avm_address), 32'd0);
    checkOutput("restart");

    chk("handshake_stability", 32'(stab_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run in case a wait above is broken.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
